// File: rtl/fetch_if_id_stage_pkg.sv
// Shared constants, types and helpers for the fetch stage and IF/ID register.
// The pcsel encoding must stay in step with the main decoder.
package fetch_if_id_stage_pkg;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'b00,
        PCSEL_REG = 2'b01,
        PCSEL_JMP = 2'b10,
        PCSEL_RSV = 2'b11
    } pcsel_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'h0000_0004;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pcplus4: 32'h0000_0000, valid: 1'b0};

    // J/JAL target: region bits of the delay-free PC+4, 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                                input logic [31:0] instr);
        return {pcplus4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory bus: fetch address out, combinational read data back.
interface fetch_if_id_stage_if;
    logic [31:0] PCF;
    logic [31:0] InstrF;

    modport master (output PCF, input InstrF);
    modport slave  (input PCF, output InstrF);
endinterface

// File: rtl/fetch_if_id_stage_if_id_reg.sv
// IF/ID pipeline register: reset, then flush (bubble), then stall (hold), then load.
module if_id_reg
    import fetch_if_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    input  logic        i_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    ifid_t r_q;

    // Flush beats stall so a squashed instruction never survives a stall cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= IFID_BUBBLE;
        end else if (i_flush) begin
            r_q <= IFID_BUBBLE;
        end else if (i_stall) begin
            r_q <= r_q;
        end else begin
            r_q <= '{instr: i_instr, pcplus4: i_pcplus4, valid: i_valid};
        end
    end

    assign o_instr   = r_q.instr;
    assign o_pcplus4 = r_q.pcplus4;
    assign o_valid   = r_q.valid;

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction fetch: PC register, next-PC selection from decode redirects,
// sticky halt flag, and the IF/ID register feeding the decoder.
module fetch_if_id_stage
    import fetch_if_id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_StallF,
    input  logic                        i_StallD,
    input  logic                        i_FlushD,
    input  logic                        i_PCSrcD,
    input  logic [1:0]                  i_pcsel,
    input  logic                        i_load,
    input  logic [31:0]                 i_PCBranchD,
    input  logic [31:0]                 i_RsD,
    fetch_if_id_stage_if.master         imem,
    output logic [31:0]                 o_InstrD,
    output logic [31:0]                 o_PCPlus4D,
    output logic                        o_validD,
    output logic                        o_halted
);

    logic [31:0] r_pc;
    logic        r_halted;

    logic [31:0] w_pcplus4F;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_act;
    logic        w_halt_req;
    logic        w_pc_load;
    logic        w_bubble;

    assign w_pcplus4F = r_pc + PC_INCR;
    assign w_redirect = i_PCSrcD | (i_pcsel == PCSEL_REG) | (i_pcsel == PCSEL_JMP);
    // Decode outputs are stale while D is stalled, so neither redirects nor HALT act then.
    assign w_act      = w_redirect & ~i_StallD & ~r_halted;
    assign w_halt_req = ~i_load & ~i_StallD & ~r_halted;
    assign w_pc_load  = (~i_StallF & ~r_halted & ~w_halt_req) | w_act;
    assign w_bubble   = i_FlushD | w_act | w_halt_req | r_halted;

    // Next-PC mux: conditional branch outranks the pcsel-driven jumps.
    always_comb begin
        w_next_pc = w_pcplus4F;
        if (i_PCSrcD) begin
            w_next_pc = i_PCBranchD;
        end else begin
            case (pcsel_e'(i_pcsel))
                PCSEL_REG: w_next_pc = i_RsD;
                PCSEL_JMP: w_next_pc = jump_target(o_PCPlus4D, o_InstrD);
                PCSEL_SEQ: w_next_pc = w_pcplus4F;
                default:   w_next_pc = w_pcplus4F;
            endcase
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_pc_load) begin
            r_pc <= w_next_pc;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Halt is remembered here because the decoder sees only NOPs afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_halt_req) begin
            r_halted <= 1'b1;
        end else begin
            r_halted <= r_halted;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .i_stall   (i_StallD),
        .i_flush   (w_bubble),
        .i_instr   (imem.InstrF),
        .i_pcplus4 (w_pcplus4F),
        .i_valid   (1'b1),
        .o_instr   (o_InstrD),
        .o_pcplus4 (o_PCPlus4D),
        .o_valid   (o_validD)
    );

    assign imem.PCF = r_pc;
    assign o_halted = r_halted;

endmodule
